// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : conv_pkg                                                        |
// | Purpose  : Shared definitions for the conv result packer: FSM state        |
// |            encoding, samples-per-word lane count and the width constants   |
// |            used by the requantiser.                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package conv_pkg;

  // Samples packed into one memory word.
  localparam int LANES = 4;

  // Extra MSB on the rounding adder so adding the half-LSB bias cannot wrap.
  localparam int ROUND_GUARD = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_word_fifo                                                    |
// | Purpose  : Synchronous show-ahead word FIFO toward the output SRAM.        |
// |            A push while full succeeds only if a pop happens in the same    |
// |            cycle. rdata reads 0 while empty.                               |
// | Ports    : clk, rst (async, active-high), flush (sync clear),              |
// |            push/wdata, pop/rdata, full, empty, last (one entry held)       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_word_fifo #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(depth));
  assign last    = (count == (AW+1)'(1));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/conv_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_result_packer                                              |
// | Purpose  : Requantises conv write-back samples (two ports, port 0 first),  |
// |            packs four per memory word and streams words to the output      |
// |            feature-map SRAM through a small FIFO that absorbs backpressure.|
// | Ports    : clk, rst (async, active-high), start_frame/base_addr,           |
// |            in0/in0_valid, in1/in1_valid, mem_wdata/mem_waddr/mem_wvalid/   |
// |            mem_wready, frame_done (pulse), overflow (sticky word drop).    |
// | Config   : CONV_PACK_RELU_EN - clamp negative results to 0 (ReLU).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module conv_result_packer
  import conv_pkg::*;
#(
  parameter int data_width    = 25,
  parameter int out_width     = 8,
  parameter int frac_shift    = 8,
  parameter int frame_samples = 3721,
  parameter int fifo_depth    = 8,
  parameter int addr_width    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_frame,
  input  logic [addr_width-1:0]        base_addr,
  input  logic [data_width-1:0]        in0,
  input  logic                         in0_valid,
  input  logic [data_width-1:0]        in1,
  input  logic                         in1_valid,
  output logic [LANES*out_width-1:0]   mem_wdata,
  output logic [addr_width-1:0]        mem_waddr,
  output logic                         mem_wvalid,
  input  logic                         mem_wready,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int WORD_W = LANES * out_width;
  localparam int CNT_W  = $clog2(frame_samples + 1);
  localparam int SUM_W  = data_width + ROUND_GUARD;
  localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(1 << (frac_shift - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((1 << (out_width - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN    = ~SAT_MAX;

  state_t state, state_nx;

  logic [data_width-1:0] smp_a, smp_b;
  logic [1:0]            smp_n;
  logic                  accept_en;
  logic [CNT_W-1:0]      sample_cnt;
  logic                  cnt_reached;

  logic [out_width-1:0]  q_a, q_b;
  logic [1:0]            q_n;

  logic [LANES-1:0][out_width-1:0] acc, merged;
  logic [1:0]            lane;
  logic [2:0]            lane_sum;
  logic                  word_done, spill;
  logic [WORD_W-1:0]     word_reg;
  logic                  word_v;

  logic                  fifo_full, fifo_empty, fifo_last, pop;

  // Round half up, arithmetic shift, then saturate (or ReLU-clamp).
  function automatic logic [out_width-1:0] quantise(input logic [data_width-1:0] x);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    sum     = SUM_W'(signed'(x)) + ROUND_BIAS;
    shifted = sum >>> frac_shift;
`ifdef CONV_PACK_RELU_EN
    if (shifted < 0) return '0;
`else
    if (shifted < SAT_MIN) return SAT_MIN[out_width-1:0];
`endif
    if (shifted > SAT_MAX) return SAT_MAX[out_width-1:0];
    return shifted[out_width-1:0];
  endfunction

  // ---------------- input acceptance ----------------
  assign cnt_reached = (sample_cnt == CNT_W'(frame_samples));
  assign accept_en   = (state == ST_RUN) && !start_frame && !cnt_reached;

  // Normalise to "first sample in smp_a" so a lone in1 behaves like in0.
  always_comb begin
    smp_a = in0;
    smp_b = in1;
    smp_n = 2'd0;
    if (accept_en) begin
      if (in0_valid && in1_valid)
        smp_n = (sample_cnt == CNT_W'(frame_samples - 1)) ? 2'd1 : 2'd2;
      else if (in0_valid)
        smp_n = 2'd1;
      else if (in1_valid) begin
        smp_a = in1;
        smp_n = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      q_a        <= '0;
      q_b        <= '0;
      q_n        <= 2'd0;
    end else if (start_frame) begin
      sample_cnt <= '0;
      q_n        <= 2'd0;
    end else begin
      sample_cnt <= sample_cnt + CNT_W'(smp_n);
      q_n        <= smp_n;
      q_a        <= quantise(smp_a);
      q_b        <= quantise(smp_b);
    end
  end

  // ---------------- packer ----------------
  // A pair arriving at lane 3 completes the word with q_a and spills q_b
  // into lane 0 of the next word.
  always_comb begin
    merged   = acc;
    lane_sum = {1'b0, lane} + {1'b0, q_n};
    if (q_n != 2'd0)                   merged[lane] = q_a;
    if (q_n == 2'd2 && lane != 2'd3)   merged[lane + 2'd1] = q_b;
    word_done = lane_sum[2];
    spill     = (q_n == 2'd2) && (lane == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      lane     <= 2'd0;
      word_reg <= '0;
      word_v   <= 1'b0;
    end else if (start_frame) begin
      acc    <= '0;
      lane   <= 2'd0;
      word_v <= 1'b0;
    end else if (state == ST_FLUSH) begin
      // Unfilled lanes are already zero because acc is cleared per word.
      word_reg <= acc;
      word_v   <= 1'b1;
      acc      <= '0;
      lane     <= 2'd0;
    end else begin
      word_v <= word_done;
      lane   <= lane_sum[1:0];
      if (word_done) begin
        word_reg <= merged;
        acc      <= '0;
        if (spill) acc[0] <= q_b;
      end else begin
        acc <= merged;
      end
    end
  end

  // ---------------- word FIFO and memory port ----------------
  wb_word_fifo #(
    .width (WORD_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_frame),
    .push  (word_v),
    .wdata (word_reg),
    .pop   (pop),
    .rdata (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  assign mem_wvalid = !fifo_empty;
  assign pop        = mem_wvalid && mem_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_waddr <= '0;
      overflow  <= 1'b0;
    end else if (start_frame) begin
      mem_waddr <= base_addr;
      overflow  <= 1'b0;
    end else begin
      if (pop) mem_waddr <= mem_waddr + addr_width'(1);
      if (word_v && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // End of frame is judged once the quantiser stage is empty so the lane
  // pointer is final. DRAIN looks one pop ahead so frame_done lands exactly
  // one cycle after the final handshake.
  always_comb begin
    state_nx   = state;
    frame_done = (state == ST_DONE);
    if (start_frame) begin
      state_nx = ST_RUN;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_RUN:   if (cnt_reached && q_n == 2'd0)
                    state_nx = (lane != 2'd0) ? ST_FLUSH : ST_DRAIN;
        ST_FLUSH: state_nx = ST_DRAIN;
        ST_DRAIN: if (!word_v && (fifo_empty || (fifo_last && pop)))
                    state_nx = ST_DONE;
        ST_DONE:  state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_conv_result_packer                                           |
// | Purpose  : Directed self-checking bench. u_dut_a uses the default frame    |
// |            length; u_dut_b uses a 6-sample frame for end-of-frame and      |
// |            drain-abort behaviour. Both share the input stimulus.           |
// | Config   : CONV_PACK_RELU_EN selects the ReLU expected values.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_conv_result_packer;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_frame = 1'b0;
  logic [15:0] base_addr = '0;
  logic [24:0] in0 = '0, in1 = '0;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic        mem_wready = 1'b1;

  logic [31:0] a_wdata, b_wdata;
  logic [15:0] a_waddr, b_waddr;
  logic        a_wvalid, b_wvalid, a_done, b_done, a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;
  logic [47:0] qa[$];
  logic [47:0] qb[$];

`ifdef CONV_PACK_RELU_EN
  localparam logic [31:0] W_ROUND = 32'h7F000102;
  localparam logic [31:0] W_SAT   = 32'h007F0000;
`else
  localparam logic [31:0] W_ROUND = 32'h7FFF0102;
  localparam logic [31:0] W_SAT   = 32'h807F0080;
`endif

  always #5 clk = ~clk;

  conv_result_packer u_dut_a (
    .clk(clk), .rst(rst), .start_frame(start_frame), .base_addr(base_addr),
    .in0(in0), .in0_valid(in0_valid), .in1(in1), .in1_valid(in1_valid),
    .mem_wdata(a_wdata), .mem_waddr(a_waddr), .mem_wvalid(a_wvalid),
    .mem_wready(mem_wready), .frame_done(a_done), .overflow(a_ovf)
  );

  conv_result_packer #(.frame_samples(6)) u_dut_b (
    .clk(clk), .rst(rst), .start_frame(start_frame), .base_addr(base_addr),
    .in0(in0), .in0_valid(in0_valid), .in1(in1), .in1_valid(in1_valid),
    .mem_wdata(b_wdata), .mem_waddr(b_waddr), .mem_wvalid(b_wvalid),
    .mem_wready(mem_wready), .frame_done(b_done), .overflow(b_ovf)
  );

  // Record every completed write as {addr, data}.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_wvalid && mem_wready) qa.push_back({a_waddr, a_wdata});
      if (b_wvalid && mem_wready) qb.push_back({b_waddr, b_wdata});
    end
  end

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input logic [15:0] addr);
    start_frame = 1'b1;
    base_addr   = addr;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic send(input logic v0, input int d0, input logic v1, input int d1);
    in0_valid = v0; in0 = d0[24:0];
    in1_valid = v1; in1 = d1[24:0];
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  initial begin
    int  hs;
    logic hs_prev, done_seen;

    // ---- reset state ----
    ticks(2);
    rst = 1'b0;
    tick();
    check_value("rst_wvalid", a_wvalid, 0);
    check_value("rst_wdata",  a_wdata,  0);
    check_value("rst_waddr",  a_waddr,  0);
    check_value("rst_done",   a_done,   0);
    check_value("rst_ovf",    a_ovf,    0);
    check_value("rst_state",  64'(u_dut_a.state), 64'(ST_IDLE));

    // ---- packing and pipeline latency ----
    start(16'h0100);
    send(1, 256, 1, 512);
    send(1, 768, 1, 1024);
    tick();
    check_value("pack_lat_early", a_wvalid, 0);
    tick();
    check_value("pack_lat_valid", a_wvalid, 1);
    check_value("pack_data", a_wdata, 32'h04030201);
    check_value("pack_addr", a_waddr, 16'h0100);
    tick();
    check_value("pack_addr_inc", a_waddr, 16'h0101);
    check_value("pack_wvalid_low", a_wvalid, 0);
    qa.delete();

    // ---- rounding and saturation (lone in1 included) ----
    send(1, 384, 1, 383);
    send(1, -384, 1, 32'h0FFFFFF);
    send(0, 0, 1, -16777216);
    send(1, 0, 1, 32512);
    send(1, -33024, 0, 0);
    ticks(6);
    check_value("round_nwords", qa.size(), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < qa.size()) begin
        check_value($sformatf("round_addr%0d", k), qa[k][47:32], 16'h0101 + 16'(k));
        check_value($sformatf("round_data%0d", k), qa[k][31:0], (k == 0) ? W_ROUND : W_SAT);
      end
    end

    // ---- backpressure and overflow ----
    start(16'h0200);
    mem_wready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(1, (4*k+1)*256, 1, (4*k+2)*256);
      send(1, (4*k+3)*256, 1, (4*k+4)*256);
    end
    ticks(4);
    check_value("bp_ovf_8", a_ovf, 0);
    check_value("bp_wvalid", a_wvalid, 1);
    check_value("bp_hold_data", a_wdata, 32'h04030201);
    check_value("bp_hold_addr", a_waddr, 16'h0200);
    send(1, 33*256, 1, 34*256);
    send(1, 35*256, 1, 36*256);
    ticks(4);
    check_value("bp_ovf_9", a_ovf, 1);
    check_value("bp_hold_data2", a_wdata, 32'h04030201);
    qa.delete();
    mem_wready = 1'b1;
    ticks(12);
    check_value("bp_nwords", qa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < qa.size()) begin
        check_value($sformatf("bp_addr%0d", k), qa[k][47:32], 16'h0200 + 16'(k));
        check_value($sformatf("bp_data%0d", k), qa[k][31:0],
                    {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
      end
    end
    check_value("bp_drained", a_wvalid, 0);

    // ---- abort in RUN clears overflow and reloads address ----
    start(16'h0280);
    check_value("abort_run_ovf", a_ovf, 0);
    check_value("abort_run_addr", a_waddr, 16'h0280);

    // ---- frame end on the 6-sample instance ----
    qb.delete();
    start(16'h0300);
    send(1, 256, 1, 512);
    send(1, 768, 1, 1024);
    send(1, 1280, 1, 1536);
    hs = 0; hs_prev = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 30 && !done_seen; i++) begin
      hs_prev = b_wvalid && mem_wready;
      if (hs_prev) hs++;
      tick();
      if (b_done) begin
        done_seen = 1'b1;
        check_value("end_done_latency", {hs_prev, 8'(hs)}, {1'b1, 8'd2});
      end
    end
    check_value("end_done_seen", done_seen, 1);
    check_value("end_nwords", qb.size(), 2);
    if (qb.size() >= 2) begin
      check_value("end_w0", qb[0], {16'h0300, 32'h04030201});
      check_value("end_w1", qb[1], {16'h0301, 32'h00000605});
    end
    tick();
    check_value("end_done_pulse", b_done, 0);
    check_value("end_idle", 64'(u_dut_b.state), 64'(ST_IDLE));

    // ---- start_frame during DRAIN ----
    start(16'h0400);
    mem_wready = 1'b0;
    send(1, 256, 1, 512);
    send(1, 768, 1, 1024);
    send(1, 1280, 1, 1536);
    ticks(8);
    check_value("drain_state", 64'(u_dut_b.state), 64'(ST_DRAIN));
    check_value("drain_wvalid", b_wvalid, 1);
    start(16'h0500);
    check_value("abort_drain_wvalid", b_wvalid, 0);
    check_value("abort_drain_addr", b_waddr, 16'h0500);
    check_value("abort_drain_ovf", b_ovf, 0);
    check_value("abort_drain_done", b_done, 0);
    qb.delete();
    mem_wready = 1'b1;
    send(1, 2560, 1, 2816);
    send(1, 3072, 1, 3328);
    ticks(6);
    check_value("abort_new_nwords", qb.size(), 1);
    if (qb.size() >= 1) check_value("abort_new_word", qb[0], {16'h0500, 32'h0D0C0B0A});

    // ---- asynchronous reset mid-frame ----
    mem_wready = 1'b0;
    send(1, 256, 1, 512);
    send(1, 768, 1, 1024);
    ticks(4);
    check_value("arst_pre_wvalid", a_wvalid, 1);
    #2 rst = 1'b1;
    #1;
    check_value("arst_wvalid", a_wvalid, 0);
    check_value("arst_wdata",  a_wdata,  0);
    check_value("arst_waddr",  a_waddr,  0);
    check_value("arst_ovf",    a_ovf,    0);
    check_value("arst_done",   a_done,   0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
